// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive path.
//   rx_state_e            - receive FSM state encoding
//   DEFAULT_CLK_FREQUENCY - default system clock in Hz
//   DEFAULT_BAUD_RATE     - default serial bit rate in bits/s
//   DEFAULT_PARITY        - default parity mode
//   PARITY_ODD/EVEN       - parity mode selectors
package uart_pkg;

  localparam int DEFAULT_CLK_FREQUENCY = 100_000_000;
  localparam int DEFAULT_BAUD_RATE     = 19_200;
  localparam int PARITY_ODD            = 1;
  localparam int PARITY_EVEN           = 0;
  localparam int DEFAULT_PARITY        = PARITY_ODD;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BITS  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4,
    ST_BREAK = 3'd5
  } rx_state_e;

endpackage

// File: rtl/uart_baud_timer.sv
// uart_baud_timer: free-running bit-period counter for the UART receiver.
//   clk      in  system clock
//   rst      in  synchronous active-high reset
//   clr      in  restart the period from zero
//   half_sel in  1 = measure HALF_TICKS cycles, 0 = measure BIT_TICKS cycles
//   done     out high on the last cycle of the selected period
// The counter restarts by itself after done, so consecutive bit periods need
// no explicit clear. It never counts beyond BIT_TICKS-1. BIT_TICKS must be >= 2.
module uart_baud_timer #(
  parameter int BIT_TICKS  = 10,
  parameter int HALF_TICKS = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic half_sel,
  output logic done
);

  localparam int CNT_W = $clog2(BIT_TICKS + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_TICKS - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_TICKS - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // >= rather than == so a switch from a full to a half period can never
  // leave the counter stranded above its terminal value.
  assign done = (cnt_q >= (half_sel ? HALF_LAST : BIT_LAST));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || done) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 8 data bits LSB first, one parity bit, one stop bit.
//   clk          in  system clock (rising edge)
//   rst          in  synchronous active-high reset
//   rx_in        in  serial line, idle high
//   dout         out last received byte
//   data_strobe  out one-cycle pulse when dout / error flags update
//   busy         out high while a frame is being received
//   parity_error out parity status of the last frame
//   frame_error  out 1 when the last stop bit was sampled low
// Build option: define UART_RX_SYNC_EN to insert a 2-flop synchronizer on
// rx_in (adds 2 cycles of latency). Without it rx_in must already be
// synchronous to clk.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQUENCY = DEFAULT_CLK_FREQUENCY,
  parameter int BAUD_RATE     = DEFAULT_BAUD_RATE,
  parameter int PARITY        = DEFAULT_PARITY
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] dout,
  output logic       data_strobe,
  output logic       busy,
  output logic       parity_error,
  output logic       frame_error
);

  localparam int BIT_TICKS  = CLK_FREQUENCY / BAUD_RATE;
  localparam int HALF_TICKS = BIT_TICKS / 2;

  function automatic logic parity_expected(input logic [7:0] data);
    return (PARITY == PARITY_ODD) ? ~^data : ^data;
  endfunction

  logic rx_s;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], rx_in};
  end

  // Reset to 1 so the idle line is not mistaken for a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rx_s = sync_q[1];
`else
  assign rx_s = rx_in;
`endif

  rx_state_e  state_q, state_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] shift_q, shift_d;
  logic       par_err_q, par_err_d;
  logic [7:0] dout_q, dout_d;
  logic       strobe_q, strobe_d;
  logic       perr_q, perr_d;
  logic       ferr_q, ferr_d;

  logic tmr_clr;
  logic tmr_half;
  logic tmr_done;

  uart_baud_timer #(
    .BIT_TICKS  (BIT_TICKS),
    .HALF_TICKS (HALF_TICKS)
  ) u_baud_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmr_clr),
    .half_sel (tmr_half),
    .done     (tmr_done)
  );

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    dout_d    = dout_q;
    strobe_d  = 1'b0;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    tmr_clr   = 1'b0;
    tmr_half  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          tmr_clr = 1'b1;
          state_d = ST_START;
        end
      end

      // Re-check the start bit at its middle to reject line glitches.
      ST_START: begin
        tmr_half = 1'b1;
        if (tmr_done) begin
          if (!rx_s) begin
            tmr_clr  = 1'b1;
            bitcnt_d = 3'd0;
            state_d  = ST_BITS;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_BITS: begin
        if (tmr_done) begin
          shift_d[bitcnt_q] = rx_s;
          if (bitcnt_q == 3'd7) begin
            state_d = ST_PAR;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end
      end

      ST_PAR: begin
        if (tmr_done) begin
          par_err_d = (rx_s != parity_expected(shift_q));
          state_d   = ST_STOP;
        end
      end

      // Leaving at the stop-bit middle gives half a bit of slack to catch
      // the start bit of a back-to-back frame in IDLE.
      ST_STOP: begin
        if (tmr_done) begin
          strobe_d = 1'b1;
          dout_d   = shift_q;
          perr_d   = par_err_q;
          ferr_d   = ~rx_s;
          state_d  = rx_s ? ST_IDLE : ST_BREAK;
        end
      end

      // A held-low line is a break, not a new start bit; wait for idle.
      ST_BREAK: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bitcnt_q  <= 3'd0;
      shift_q   <= 8'h00;
      par_err_q <= 1'b0;
      dout_q    <= 8'h00;
      strobe_q  <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      dout_q    <= dout_d;
      strobe_q  <= strobe_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  assign dout         = dout_q;
  assign data_strobe  = strobe_q;
  assign parity_error = perr_q;
  assign frame_error  = ferr_q;
  assign busy         = (state_q == ST_START) || (state_q == ST_BITS) ||
                        (state_q == ST_PAR)   || (state_q == ST_STOP);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx with one odd-parity and one
// even-parity instance sharing the same serial line.
module tb_uart_rx;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int BIT    = CLK_HZ / BAUD;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic rx_in;

  logic [7:0] dout_o, dout_e;
  logic       stb_o, stb_e, busy_o, busy_e, pe_o, pe_e, fe_o, fe_e;

  int compared   = 0;
  int mismatched = 0;
  bit mon_en     = 0;

  exp_t q_odd[$];
  exp_t q_even[$];
  exp_t hold[2];

  always #5 clk = ~clk;

  uart_rx #(.CLK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD), .PARITY(1)) dut_odd (
    .clk(clk), .rst(rst), .rx_in(rx_in), .dout(dout_o), .data_strobe(stb_o),
    .busy(busy_o), .parity_error(pe_o), .frame_error(fe_o));

  uart_rx #(.CLK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD), .PARITY(0)) dut_even (
    .clk(clk), .rst(rst), .rx_in(rx_in), .dout(dout_e), .data_strobe(stb_e),
    .busy(busy_e), .parity_error(pe_e), .frame_error(fe_e));

  // Parity bit a correct transmitter would send, from a count of ones.
  function automatic logic good_parity(input logic [7:0] d, input bit odd);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(d[i]);
    return odd ? ((n % 2) == 0) : ((n % 2) == 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [7:0] d, input logic pb, input logic sb);
    exp_t e;
    e.d  = d;
    e.fe = ~sb;
    e.pe = (pb != good_parity(d, 1'b1));
    q_odd.push_back(e);
    e.pe = (pb != good_parity(d, 1'b0));
    q_even.push_back(e);
  endtask

  task automatic check_inst(input int k, input logic stb, input logic [7:0] d,
                            input logic pe, input logic fe);
    exp_t e;
    bit   have;
    have = 0;
    e    = '0;
    if (stb === 1'b1) begin
      if (k == 0 && q_odd.size() > 0) begin
        e = q_odd.pop_front(); have = 1;
      end else if (k == 1 && q_even.size() > 0) begin
        e = q_even.pop_front(); have = 1;
      end
      compared++;
      if (!have) begin
        mismatched++;
        $display("FAIL strobe_inst%0d: unexpected strobe dout=%0h, no frame outstanding", k, d);
      end else begin
        if ({d, pe, fe} !== {e.d, e.pe, e.fe}) begin
          mismatched++;
          $display("FAIL frame_inst%0d: got dout=%0h pe=%b fe=%b expected dout=%0h pe=%b fe=%b",
                   k, d, pe, fe, e.d, e.pe, e.fe);
        end
        hold[k] = e;
      end
    end else begin
      compared++;
      if ({d, pe, fe} !== {hold[k].d, hold[k].pe, hold[k].fe} || stb !== 1'b0) begin
        mismatched++;
        $display("FAIL hold_inst%0d: got stb=%b dout=%0h pe=%b fe=%b expected stb=0 dout=%0h pe=%b fe=%b",
                 k, stb, d, pe, fe, hold[k].d, hold[k].pe, hold[k].fe);
      end
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (mon_en) begin
      check_inst(0, stb_o, dout_o, pe_o, fe_o);
      check_inst(1, stb_e, dout_e, pe_e, fe_e);
    end
  end

  // Bits go out at negedges; abort_bit >= 0 resets the DUTs mid-way through
  // that bit position (0 = start, 1..8 = data, 9 = parity, 10 = stop).
  task automatic send_frame(input logic [7:0] d, input logic pb, input logic sb,
                            input int abort_bit);
    logic [10:0] bits;
    bits = {sb, pb, d, 1'b0};
    if (abort_bit < 0) push_frame(d, pb, sb);
    for (int i = 0; i < 11; i++) begin
      rx_in = bits[i];
      for (int c = 0; c < BIT; c++) begin
        if (i == abort_bit && c == 5) begin
          rx_in   = 1'b1;
          rst     = 1'b1;
          hold[0] = '0;
          hold[1] = '0;
          @(negedge clk);
          rst = 1'b0;
          chk("abort_busy_odd", 32'(busy_o), 32'd0);
          chk("abort_busy_even", 32'(busy_e), 32'd0);
          chk("abort_dout_odd", 32'(dout_o), 32'd0);
          return;
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    logic [7:0] d;
    logic       pb;
    rst     = 1'b1;
    rx_in   = 1'b1;
    hold[0] = '0;
    hold[1] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'({busy_o, busy_e}), 32'd0);
    chk("rst_strobe", 32'({stb_o, stb_e}), 32'd0);
    chk("rst_dout", 32'({dout_o, dout_e}), 32'd0);
    chk("rst_flags", 32'({pe_o, fe_o, pe_e, fe_e}), 32'd0);
    mon_en = 1;
    repeat (5) @(negedge clk);

    // Odd parity 0xA5, correct then wrong parity bit.
    send_frame(8'hA5, 1'b1, 1'b1, -1);
    repeat (5) @(negedge clk);
    send_frame(8'hA5, 1'b0, 1'b1, -1);
    repeat (5) @(negedge clk);

    // Stop bit low followed by a held-low line (break).
    send_frame(8'h5A, good_parity(8'h5A, 1'b1), 1'b0, -1);
    rx_in = 1'b0;
    repeat (15) @(negedge clk);
    chk("break_busy_mid", 32'({busy_o, busy_e}), 32'd0);
    repeat (15) @(negedge clk);
    chk("break_busy_end", 32'({busy_o, busy_e}), 32'd0);
    rx_in = 1'b1;
    repeat (10) @(negedge clk);
    send_frame(8'h11, good_parity(8'h11, 1'b1), 1'b1, -1);
    repeat (5) @(negedge clk);

    // Short glitch on the line.
    rx_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("glitch_busy_high", 32'({busy_o, busy_e}), 32'h3);
    @(negedge clk);
    rx_in = 1'b1;
    repeat (10) @(negedge clk);
    chk("glitch_busy_low", 32'({busy_o, busy_e}), 32'd0);

    // Reset during data bit 4, then a clean frame.
    send_frame(8'hE7, 1'b0, 1'b1, 5);
    repeat (10) @(negedge clk);
    send_frame(8'h3C, good_parity(8'h3C, 1'b1), 1'b1, -1);
    repeat (5) @(negedge clk);

    // Back-to-back, even parity bits.
    send_frame(8'h00, good_parity(8'h00, 1'b0), 1'b1, -1);
    send_frame(8'hFF, good_parity(8'hFF, 1'b0), 1'b1, -1);

    // Random frames, some back-to-back, random parity bit.
    for (int n = 0; n < 40; n++) begin
      d  = 8'($urandom);
      pb = 1'($urandom);
      send_frame(d, pb, 1'b1, -1);
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end

    rx_in = 1'b1;
    for (int w = 0; w < 100 && (q_odd.size() + q_even.size()) > 0; w++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("outstanding_odd", 32'(q_odd.size()), 32'd0);
    chk("outstanding_even", 32'(q_even.size()), 32'd0);
    mon_en = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
